// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
//
// Shares the single pmem cacheline port between the I-cache and the D-cache.
// A three-state FSM (IDLE, I_BUSY, D_BUSY) grants one requester at a time.
// On a grant it latches the line-aligned address, the writeback line and the
// access kind. It then presents them to pmem until pmem_resp, which passes
// straight through as the requester's resp in the same cycle.
//
// Optional build macro: ARB_ROUND_ROBIN_EN
//   defined   : a simultaneous I+D request in IDLE grants the side not
//               granted last. Last-grant resets to I, so the first tie goes
//               to D.
//   undefined : fixed priority. D always wins a tie, because its instruction
//               is older in the pipeline.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   i_read/i_addr             I-cache line-fill request
//   i_rdata/i_resp            fill data / completion to I-cache
//   d_read/d_write/d_addr     D-cache request (read+write together = write)
//   d_wdata                   D-cache writeback line
//   d_rdata/d_resp            fill data / completion to D-cache
//   pmem_read/pmem_write      memory strobes (decoded from state)
//   pmem_addr/pmem_wdata      registered line address / write line
//   pmem_rdata/pmem_resp      memory read line / completion
//   arb_busy                  high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              arb_busy
);

    localparam int OFF_W = $clog2(LINE_W / 8);
    // Clears the byte-offset bits so that pmem always sees a line-aligned address.
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [LINE_W-1:0] wdata_reg;
    logic              write_reg;

    logic i_req;
    logic d_req;
    logic grant_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = D was granted last, 0 = I was granted last.
    logic last_d_reg;
    // On a tie, D wins only if I was granted last.
    assign grant_d = d_req & (~i_req | ~last_d_reg);
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            write_reg  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_d) begin
                        addr_reg   <= d_addr & LINE_MASK;
                        wdata_reg  <= d_wdata;
                        write_reg  <= d_write;  // read+write together is a write
                        state_reg  <= D_BUSY;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d_reg <= 1'b1;
`endif
                    end else if (i_req) begin
                        addr_reg   <= i_addr & LINE_MASK;
                        write_reg  <= 1'b0;
                        state_reg  <= I_BUSY;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d_reg <= 1'b0;
`endif
                    end
                end
                // A granted transaction always runs to pmem_resp, even if the
                // requester has dropped its request.
                I_BUSY, D_BUSY: begin
                    if (pmem_resp) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // The strobes are decoded from the state alone, so an asynchronous reset
    // drops them at once and they stay stable for the whole transaction.
    assign pmem_read  = (state_reg == I_BUSY) | ((state_reg == D_BUSY) & ~write_reg);
    assign pmem_write = (state_reg == D_BUSY) & write_reg;
    assign pmem_addr  = addr_reg;
    assign pmem_wdata = wdata_reg;
    assign arb_busy   = (state_reg != IDLE);

    // pmem_resp passes through with no delay. It is ignored in IDLE.
    assign i_resp  = (state_reg == I_BUSY) & pmem_resp;
    assign d_resp  = (state_reg == D_BUSY) & pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_arbiter
//
// Table-driven bench for cache_mem_arbiter. Each record holds one complete
// transaction: the request inputs, the pmem response delay and response line,
// and the expected grant, strobes and aligned address. Multi-cycle corner
// cases are written out by hand: the requester drops its request while busy,
// pmem_resp arrives in IDLE, and reset arrives mid-transaction. Tie
// expectations follow ARB_ROUND_ROBIN_EN in the same way the design does.
// -----------------------------------------------------------------------------
module tb_cache_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              arb_busy;

    int checks;
    int failures;

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_read     (i_read),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_addr  (pmem_addr),
        .pmem_wdata (pmem_wdata),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp),
        .arb_busy   (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              i_read;
        logic              d_read;
        logic              d_write;
        logic [ADDR_W-1:0] i_addr;
        logic [ADDR_W-1:0] d_addr;
        logic [LINE_W-1:0] d_wdata;
        logic [LINE_W-1:0] rdata;
        int                delay;
        logic              exp_i;     // 1: I side granted, 0: D side granted
        logic              exp_read;
        logic              exp_write;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ir, input logic dr, input logic dw,
                                input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                                input logic [LINE_W-1:0] wd, input logic [LINE_W-1:0] rd,
                                input int dly, input logic ei, input logic er,
                                input logic ew, input logic [ADDR_W-1:0] ea);
        vec_t v;
        v.i_read = ir; v.d_read = dr; v.d_write = dw;
        v.i_addr = ia; v.d_addr = da; v.d_wdata = wd; v.rdata = rd;
        v.delay = dly; v.exp_i = ei; v.exp_read = er; v.exp_write = ew;
        v.exp_addr = ea;
        return v;
    endfunction

    // Runs one full transaction. The request is driven in an idle cycle and
    // held until the response cycle. The edge after the response must return
    // the FSM to IDLE while pmem_resp is still high.
    task automatic run_vec(input int k, input vec_t v);
        @(negedge clk);
        i_read  = v.i_read;
        d_read  = v.d_read;
        d_write = v.d_write;
        i_addr  = v.i_addr;
        d_addr  = v.d_addr;
        d_wdata = v.d_wdata;
        pmem_resp = 1'b0;
        #1;
        check("idle_busy",  {255'd0, arb_busy},   256'd0);
        check("idle_read",  {255'd0, pmem_read},  256'd0);
        check("idle_write", {255'd0, pmem_write}, 256'd0);

        @(posedge clk); #1;
        check("grant_busy",  {255'd0, arb_busy},   256'd1);
        check("grant_read",  {255'd0, pmem_read},  {255'd0, v.exp_read});
        check("grant_write", {255'd0, pmem_write}, {255'd0, v.exp_write});
        check("grant_addr",  {224'd0, pmem_addr},  {224'd0, v.exp_addr});
        if (v.exp_write)
            check("grant_wdata", pmem_wdata, v.d_wdata);

        for (int c = 0; c < v.delay; c++) begin
            @(posedge clk); #1;
            check("hold_strobe", {254'd0, pmem_read, pmem_write},
                  {254'd0, v.exp_read, v.exp_write});
            check("hold_resp", {254'd0, i_resp, d_resp}, 256'd0);
        end

        @(negedge clk);
        pmem_rdata = v.rdata;
        pmem_resp  = 1'b1;
        #1;
        check("resp_i", {255'd0, i_resp}, {255'd0, v.exp_i});
        check("resp_d", {255'd0, d_resp}, {255'd0, ~v.exp_i});
        if (v.exp_i)
            check("i_rdata", i_rdata, v.rdata);
        else
            check("d_rdata", d_rdata, v.rdata);

        @(posedge clk); #1;
        check("post_busy", {255'd0, arb_busy}, 256'd0);
        check("post_resp", {254'd0, i_resp, d_resp}, 256'd0);
        check("post_read", {255'd0, pmem_read}, 256'd0);
        $display("vec %0d: grant=%s addr=%08h read=%0d write=%0d", k,
                 v.exp_i ? "I" : "D", pmem_addr, v.exp_read, v.exp_write);
    endtask

    initial begin
        logic [LINE_W-1:0] pat_a;
        logic [31:0]       w;
        logic [LINE_W-1:0] rd[NVEC];
        vec_t              dv;

        checks   = 0;
        failures = 0;
        pat_a    = {8{32'hA5A5_0F0F}};
        for (int k = 0; k < NVEC; k++) begin
            w     = 32'hC0DE_0000 | 32'(k);
            rd[k] = {8{w}};
        end

        //             ir    dr    dw    i_addr        d_addr        wdata   rdata  dly exp_i  rd    wr    exp_addr
        vecs[0] = mk(1'b1, 1'b0, 1'b0, 32'h0000_106C, 32'h0,        '0,     rd[0], 3, 1'b1, 1'b1, 1'b0, 32'h0000_1060);
        vecs[1] = mk(1'b0, 1'b0, 1'b1, 32'h0,        32'h8000_0024, pat_a,  rd[1], 2, 1'b0, 1'b0, 1'b1, 32'h8000_0020);
        vecs[2] = mk(1'b1, 1'b0, 1'b0, 32'h0000_0FFF, 32'h0,        '0,     rd[2], 0, 1'b1, 1'b1, 1'b0, 32'h0000_0FE0);
        // Three ties in a row. Last grant before them is I.
        vecs[3] = mk(1'b1, 1'b1, 1'b0, 32'h0000_4010, 32'h0000_5033, '0,    rd[3], 1, 1'b0, 1'b1, 1'b0, 32'h0000_5020);
        vecs[4] = mk(1'b1, 1'b1, 1'b0, 32'h0000_4010, 32'h0000_5033, '0,    rd[4], 1, RR,   1'b1, 1'b0,
                     RR ? 32'h0000_4000 : 32'h0000_5020);
        vecs[5] = mk(1'b1, 1'b1, 1'b0, 32'h0000_4010, 32'h0000_5033, '0,    rd[5], 1, 1'b0, 1'b1, 1'b0, 32'h0000_5020);
        // Back-to-back D reads.
        vecs[6] = mk(1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_2047, '0,     rd[6], 0, 1'b0, 1'b1, 1'b0, 32'h0000_2040);
        vecs[7] = mk(1'b0, 1'b1, 1'b0, 32'h0,        32'hFFFF_FFFF, '0,     rd[7], 0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFE0);
        // Read and write together is a write.
        vecs[8] = mk(1'b0, 1'b1, 1'b1, 32'h0,        32'h1234_567F, ~pat_a, rd[8], 1, 1'b0, 1'b0, 1'b1, 32'h1234_5660);
        // Tie with a write on the D side. Last grant is D, so RR picks I.
        vecs[9] = mk(1'b1, 1'b0, 1'b1, 32'h0000_7001, 32'h0000_9000, pat_a, rd[9], 0, RR,   RR,   ~RR,
                     RR ? 32'h0000_7000 : 32'h0000_9000);

        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b1;
        #12;
        check("rst_busy",   {255'd0, arb_busy},   256'd0);
        check("rst_strobe", {254'd0, pmem_read, pmem_write}, 256'd0);
        check("rst_resp",   {254'd0, i_resp, d_resp}, 256'd0);
        check("rst_addr",   {224'd0, pmem_addr},  256'd0);
        check("rst_wdata",  pmem_wdata,           256'd0);
        @(negedge clk);
        rst = 1'b0;
        pmem_resp = 1'b0;

        for (int k = 0; k < NVEC; k++)
            run_vec(k, vecs[k]);

        // The request is dropped while D_BUSY. The transaction still
        // completes, and a later pmem_resp in IDLE is ignored.
        @(negedge clk);
        i_read = 1'b0; d_write = 1'b0; d_read = 1'b1; d_addr = 32'h0000_3A5C;
        pmem_resp = 1'b0;
        @(posedge clk); #1;
        check("drop_grant", {224'd0, pmem_addr}, {224'd0, 32'h0000_3A40});
        @(negedge clk);
        d_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("drop_hold", {255'd0, pmem_read}, 256'd1);
        @(negedge clk);
        pmem_rdata = {8{32'hDEAD_BEEF}};
        pmem_resp  = 1'b1;
        #1;
        check("drop_resp", {255'd0, d_resp}, 256'd1);
        check("drop_rdata", d_rdata, {8{32'hDEAD_BEEF}});
        @(negedge clk);
        check("drop_idle", {255'd0, arb_busy}, 256'd0);
        pmem_resp = 1'b0;
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        check("idle_resp_ignored", {254'd0, i_resp, d_resp}, 256'd0);
        @(posedge clk); #1;
        check("idle_stays", {255'd0, arb_busy}, 256'd0);
        $display("seq drop: d_resp after drop, IDLE resp ignored");

        // Reset arrives mid-I_BUSY. The strobe drops at once and no resp is
        // issued. A D read is then granted normally.
        @(negedge clk);
        pmem_resp = 1'b0;
        i_read = 1'b1; i_addr = 32'h0000_ABCD;
        @(posedge clk); #1;
        check("rst_mid_read_before", {255'd0, pmem_read}, 256'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_read", {255'd0, pmem_read}, 256'd0);
        check("rst_mid_busy", {255'd0, arb_busy}, 256'd0);
        pmem_resp = 1'b1;
        #1;
        check("rst_mid_resp", {255'd0, i_resp}, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        i_read = 1'b0;
        pmem_resp = 1'b0;
        $display("seq reset: mid I_BUSY aborted");
        dv = mk(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0440, '0, {8{32'h0F0F_5A5A}}, 1,
                1'b0, 1'b1, 1'b0, 32'h0000_0440);
        run_vec(NVEC, dv);

        @(negedge clk);
        d_read = 1'b0;
        pmem_resp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
